packet_tx_serializer: RTL and testbench

Downstream stage of the reward packer. Captures the eight packed reward fields on each reward_done pulse and holds them in a small packet FIFO. It then gains the channel through a CSMA-style idle-sense plus random backoff, and serializes each packet word-by-word onto a valid/ready transmit bus toward the radio/MAC interface. It is the only path by which a node emits HB, INV, MR, CH-timeslot and data/SOS packets.

---
 rtl/eer_pkg.sv | 52 +++++
 rtl/packet_tx_serializer_if.sv | 19 +
 rtl/pkt_fifo.sv | 66 ++++++
 rtl/packet_tx_serializer.sv | 207 ++++++++++++++++++++
 tb/tb_packet_tx_serializer.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eer_pkg.sv
// rtl/eer_pkg.sv - shared constants, enums and LFSR helper for the packet tx serializer
// Purpose: packet geometry, field order on the wire, packet-type codes,
//          tx FSM state encoding and the backoff LFSR step function.
package eer_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int PKT_WORDS  = 8;

  localparam int DEFAULT_QDEPTH      = 4;
  localparam int DEFAULT_DIFS_CYCLES = 8;
  localparam int DEFAULT_BO_BITS     = 5;

  localparam logic [15:0] LFSR_FALLBACK_SEED = 16'hACE1;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef logic [PKT_WORDS-1:0][WORD_WIDTH-1:0] pkt_t;

  // Word position of each field on the wire
  typedef enum logic [2:0] {
    W_PTYPE     = 3'd0,
    W_SRC       = 3'd1,
    W_DST       = 3'd2,
    W_SRC_HOPS  = 3'd3,
    W_CH        = 3'd4,
    W_HOPS_CH   = 3'd5,
    W_QVALUE    = 3'd6,
    W_ENERGY    = 3'd7
  } field_idx_e;

  typedef enum logic [WORD_WIDTH-1:0] {
    PT_HB      = 16'h0001,
    PT_INV     = 16'h0002,
    PT_MR      = 16'h0003,
    PT_CH_TS   = 16'h0004,
    PT_DATA    = 16'h0005,
    PT_SOS     = 16'h0006
  } pkt_type_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DIFS    = 3'd1,
    S_BACKOFF = 3'd2,
    S_SEND    = 3'd3,
    S_DONE    = 3'd4
  } tx_state_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/packet_tx_serializer_if.sv
// rtl/packet_tx_serializer_if.sv - valid/ready transmit word bus toward the radio/MAC
// Purpose: groups the tx word stream.
// Signals: tx_data (word), tx_valid, tx_sop (word 0), tx_eop (last word),
//          tx_ready (sink accepts when tx_valid & tx_ready).
interface packet_tx_serializer_if;
  import eer_pkg::*;

  word_t tx_data;
  logic  tx_valid;
  logic  tx_sop;
  logic  tx_eop;
  logic  tx_ready;

  modport master (output tx_data, output tx_valid, output tx_sop, output tx_eop,
                  input  tx_ready);
  modport slave  (input  tx_data, input  tx_valid, input  tx_sop, input  tx_eop,
                  output tx_ready);

endinterface

// File: rtl/pkt_fifo.sv
// rtl/pkt_fifo.sv - whole-packet FIFO with word-indexed head read
// Purpose: QDEPTH slots of PKT_WORDS x WORD_WIDTH. A push writes a full packet
//          into the tail slot; pop releases the head slot.
// Ports: clk, nrst (sync, active-high), push/push_pkt, pop, rd_idx -> rd_word
//        (combinational read of the head packet), count (packets held), full.
module pkt_fifo
  import eer_pkg::*;
#(
  parameter int QDEPTH = DEFAULT_QDEPTH
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           push,
  input  pkt_t                           push_pkt,
  input  logic                           pop,
  input  logic [$clog2(PKT_WORDS)-1:0]   rd_idx,
  output word_t                          rd_word,
  output logic [$clog2(QDEPTH):0]        count,
  output logic                           full
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  pkt_t           mem_q [QDEPTH];
  pkt_t           mem_d [QDEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push_ok, pop_ok;

  assign full    = (count_q == CW'(QDEPTH));
  assign count   = count_q;
  assign rd_word = mem_q[rd_ptr_q][rd_idx];

  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_pkt;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    // Storage contents need no reset; flushing is done by the pointers/count
    mem_q <= mem_d;
    if (nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/packet_tx_serializer.sv
// rtl/packet_tx_serializer.sv - packet capture FIFO, CSMA channel access and word serializer
// Purpose: captures the eight reward fields on reward_done[0], queues them,
//          waits for DIFS idle (with random backoff on busy) and sends each
//          packet word-by-word on the tx bus.
// Ports: clk, nrst (sync, active-high), myNodeID (LFSR seed), reward_done,
//        r* packet fields, ch_busy (carrier sense), tx (bus master),
//        tx_done (pulse after last word), pkt_drop (capture lost, FIFO full),
//        pkt_count (queued packets incl. the one in flight).
module packet_tx_serializer
  import eer_pkg::*;
#(
  parameter int QDEPTH      = DEFAULT_QDEPTH,
  parameter int DIFS_CYCLES = DEFAULT_DIFS_CYCLES,
  parameter int BO_BITS     = DEFAULT_BO_BITS
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  word_t                    myNodeID,
  input  word_t                    reward_done,
  input  word_t                    rPacketType,
  input  word_t                    rSourceID,
  input  word_t                    rDestinationID,
  input  word_t                    rSourceHops,
  input  word_t                    rChosenCH,
  input  word_t                    rHopsFromCH,
  input  word_t                    rQValue,
  input  word_t                    rEnergyLeft,
  input  logic                     ch_busy,
  packet_tx_serializer_if.master   tx,
  output logic                     tx_done,
  output logic                     pkt_drop,
  output logic [$clog2(QDEPTH):0]  pkt_count
);

  localparam int IW = $clog2(PKT_WORDS);
  localparam int DW = $clog2(DIFS_CYCLES + 1);
  localparam int BW = BO_BITS + 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(PKT_WORDS - 1);
  localparam logic [DW-1:0] DIFS_LOAD = DW'(DIFS_CYCLES);

  tx_state_e       state_q, state_d;
  logic [DW-1:0]   difs_cnt_q, difs_cnt_d;
  logic [BW-1:0]   bo_cnt_q, bo_cnt_d;
  logic [IW-1:0]   word_idx_q, word_idx_d;
  logic [15:0]     lfsr_q, lfsr_d;
  word_t           tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            tx_sop_q, tx_sop_d;
  logic            tx_eop_q, tx_eop_d;
  logic            tx_done_q, tx_done_d;
  logic            pkt_drop_q, pkt_drop_d;

  pkt_t                 push_pkt;
  logic                 fifo_push, fifo_pop, fifo_full;
  logic [IW-1:0]        rd_idx;
  word_t                rd_word;
  logic [$clog2(QDEPTH):0] fifo_count;
  logic                 hs;
  logic                 unused_reward_bits;

  assign unused_reward_bits = ^reward_done[WORD_WIDTH-1:1];

  always_comb begin
    push_pkt              = '0;
    push_pkt[W_PTYPE]     = rPacketType;
    push_pkt[W_SRC]       = rSourceID;
    push_pkt[W_DST]       = rDestinationID;
    push_pkt[W_SRC_HOPS]  = rSourceHops;
    push_pkt[W_CH]        = rChosenCH;
    push_pkt[W_HOPS_CH]   = rHopsFromCH;
    push_pkt[W_QVALUE]    = rQValue;
    push_pkt[W_ENERGY]    = rEnergyLeft;
  end

  // Fullness is judged on the registered count, so a slot freed by a
  // coincident final-word pop is not reusable until the next cycle.
  assign fifo_push = reward_done[0] & ~fifo_full;

  // Head read index: word 0 when launching a packet, otherwise the word that
  // follows the one currently presented.
  assign rd_idx = (state_q == S_SEND) ? word_idx_q + IW'(1) : '0;

  assign hs = tx_valid_q & tx.tx_ready;

  pkt_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk      (clk),
    .nrst     (nrst),
    .push     (fifo_push),
    .push_pkt (push_pkt),
    .pop      (fifo_pop),
    .rd_idx   (rd_idx),
    .rd_word  (rd_word),
    .count    (fifo_count),
    .full     (fifo_full)
  );

  always_comb begin
    state_d    = state_q;
    difs_cnt_d = difs_cnt_q;
    bo_cnt_d   = bo_cnt_q;
    word_idx_d = word_idx_q;
    lfsr_d     = lfsr_next(lfsr_q);
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_sop_d   = tx_sop_q;
    tx_eop_d   = tx_eop_q;
    tx_done_d  = 1'b0;
    pkt_drop_d = reward_done[0] & fifo_full;
    fifo_pop   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fifo_count != '0) begin
          state_d    = S_DIFS;
          difs_cnt_d = DIFS_LOAD;
        end
      end
      S_DIFS: begin
        if (ch_busy) begin
          state_d  = S_BACKOFF;
          bo_cnt_d = BW'(lfsr_q[BO_BITS-1:0]) + BW'(1);
        end else if (difs_cnt_q == DW'(1)) begin
          // Last required idle cycle: present word 0 next cycle
          state_d    = S_SEND;
          word_idx_d = '0;
          tx_valid_d = 1'b1;
          tx_data_d  = rd_word;
          tx_sop_d   = 1'b1;
          tx_eop_d   = (LAST_IDX == '0);
        end else begin
          difs_cnt_d = difs_cnt_q - DW'(1);
        end
      end
      S_BACKOFF: begin
        // Countdown frozen while the medium is busy
        if (!ch_busy) begin
          if (bo_cnt_q == BW'(1)) begin
            state_d    = S_DIFS;
            difs_cnt_d = DIFS_LOAD;
          end else begin
            bo_cnt_d = bo_cnt_q - BW'(1);
          end
        end
      end
      S_SEND: begin
        if (hs) begin
          if (word_idx_q == LAST_IDX) begin
            fifo_pop   = 1'b1;
            state_d    = S_DONE;
            tx_valid_d = 1'b0;
            tx_sop_d   = 1'b0;
            tx_eop_d   = 1'b0;
            tx_done_d  = 1'b1;
          end else begin
            word_idx_d = word_idx_q + IW'(1);
            tx_data_d  = rd_word;
            tx_sop_d   = 1'b0;
            tx_eop_d   = ((word_idx_q + IW'(1)) == LAST_IDX);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q    <= S_IDLE;
      difs_cnt_q <= '0;
      bo_cnt_q   <= '0;
      word_idx_q <= '0;
      lfsr_q     <= (myNodeID == '0) ? LFSR_FALLBACK_SEED : myNodeID;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      pkt_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      difs_cnt_q <= difs_cnt_d;
      bo_cnt_q   <= bo_cnt_d;
      word_idx_q <= word_idx_d;
      lfsr_q     <= lfsr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      tx_done_q  <= tx_done_d;
      pkt_drop_q <= pkt_drop_d;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_sop   = tx_sop_q;
  assign tx.tx_eop   = tx_eop_q;
  assign tx_done     = tx_done_q;
  assign pkt_drop    = pkt_drop_q;
  assign pkt_count   = fifo_count;

endmodule

// File: tb/tb_packet_tx_serializer.sv
// tb/tb_packet_tx_serializer.sv - self-checking bench for packet_tx_serializer
module tb_packet_tx_serializer;
  import eer_pkg::*;

  localparam int QD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst;
  word_t      my_node_id;
  word_t      reward_done;
  word_t      fld [PKT_WORDS];
  logic       ch_busy;
  logic       tx_done;
  logic       pkt_drop;
  logic [2:0] pkt_count;

  packet_tx_serializer_if txb ();

  packet_tx_serializer dut (
    .clk            (clk),
    .nrst           (nrst),
    .myNodeID       (my_node_id),
    .reward_done    (reward_done),
    .rPacketType    (fld[0]),
    .rSourceID      (fld[1]),
    .rDestinationID (fld[2]),
    .rSourceHops    (fld[3]),
    .rChosenCH      (fld[4]),
    .rHopsFromCH    (fld[5]),
    .rQValue        (fld[6]),
    .rEnergyLeft    (fld[7]),
    .ch_busy        (ch_busy),
    .tx             (txb),
    .tx_done        (tx_done),
    .pkt_drop       (pkt_drop),
    .pkt_count      (pkt_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of whole packets plus the position of the word on the wire
  pkt_t        m_q [$];
  int          m_count, m_widx, m_pops;
  logic        m_done_exp, m_drop_exp, m_after_rst;
  logic        hold_pending, prev_valid;
  word_t       hold_data;
  logic [7:0]  busy_hist;
  logic [15:0] m_lfsr;
  word_t       seen [$];
  int          n_done, n_drops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic pkt_t cur_pkt();
    pkt_t p;
    for (int i = 0; i < PKT_WORDS; i++) p[i] = fld[i];
    return p;
  endfunction

  // One clock: predict the effect of the coming edge from the inputs and the
  // currently presented outputs, then check everything at the falling edge.
  task automatic tick();
    logic hs, last, push, drop;
    hs = txb.tx_valid & txb.tx_ready;
    if (nrst) begin
      m_q.delete();
      m_count      = 0;
      m_widx       = 0;
      m_done_exp   = 1'b0;
      m_drop_exp   = 1'b0;
      m_lfsr       = (my_node_id == 16'h0) ? 16'hACE1 : my_node_id;
      busy_hist    = 8'hFF;
      hold_pending = 1'b0;
      m_after_rst  = 1'b1;
    end else begin
      push = reward_done[0] && (m_count < QD);
      drop = reward_done[0] && (m_count == QD);
      last = hs && (m_widx == PKT_WORDS - 1);
      if (hs) seen.push_back(txb.tx_data);
      if (push) m_q.push_back(cur_pkt());
      if (last) begin
        void'(m_q.pop_front());
        m_widx = 0;
        m_pops++;
      end else if (hs) begin
        m_widx++;
      end
      m_count      = m_count + (push ? 1 : 0) - (last ? 1 : 0);
      m_done_exp   = last;
      m_drop_exp   = drop;
      hold_pending = txb.tx_valid && !txb.tx_ready;
      hold_data    = txb.tx_data;
      busy_hist    = {busy_hist[6:0], ch_busy};
      m_lfsr       = lfsr_step(m_lfsr);
      m_after_rst  = 1'b0;
    end
    @(negedge clk);
    check("pkt_count", pkt_count, m_count);
    check("tx_done", tx_done, m_done_exp);
    check("pkt_drop", pkt_drop, m_drop_exp);
    if (m_after_rst) begin
      check("rst_tx_valid", txb.tx_valid, 0);
      check("rst_tx_data", txb.tx_data, 0);
    end
    if (hold_pending) begin
      check("hold_valid", txb.tx_valid, 1);
      check("hold_data", txb.tx_data, hold_data);
    end
    if (txb.tx_valid) begin
      if (m_q.size() == 0) begin
        check("valid_with_empty_queue", txb.tx_valid, 0);
      end else begin
        check("tx_data", txb.tx_data, m_q[0][m_widx]);
        check("tx_sop", txb.tx_sop, (m_widx == 0));
        check("tx_eop", txb.tx_eop, (m_widx == PKT_WORDS - 1));
      end
      if (!prev_valid) check("difs_idle_before_send", busy_hist, 8'h00);
    end else begin
      check("sop_eop_idle", {txb.tx_sop, txb.tx_eop}, 2'b00);
    end
    if (tx_done) n_done++;
    if (pkt_drop) n_drops++;
    prev_valid = txb.tx_valid;
  endtask

  task automatic do_reset();
    nrst = 1'b1;
    reward_done = '0;
    ch_busy = 1'b0;
    txb.tx_ready = 1'b1;
    tick();
    tick();
    nrst = 1'b0;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < PKT_WORDS; i++) fld[i] = word_t'($urandom);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!txb.tx_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    ch_busy = 1'b0;
    txb.tx_ready = 1'b1;
    reward_done = '0;
    while (m_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    check("drain_complete", m_q.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    int n, st3, st4, bo_exp;
    word_t new0;
    logic [15:0] seeds [2];
    word_t basic [PKT_WORDS];

    nrst = 1'b1;
    reward_done = '0;
    ch_busy = 1'b0;
    txb.tx_ready = 1'b1;
    my_node_id = 16'h1D2F;
    prev_valid = 1'b0;
    m_pops = 0;
    n_done = 0;
    n_drops = 0;
    for (int i = 0; i < PKT_WORDS; i++) fld[i] = '0;

    // Basic send and first-word latency
    do_reset();
    repeat (3) tick();
    basic = '{16'h0002, 16'h0011, 16'h00FF, 16'h0003, 16'h0005, 16'h0001, 16'h1234, 16'h0F00};
    fld = basic;
    seen.delete();
    n_done = 0;
    reward_done = 16'h0001;
    tick();
    reward_done = '0;
    check("basic_count_after_capture", pkt_count, 1);
    wait_valid(100, n);
    check("basic_first_valid_cycle", n + 1, 10);
    drain();
    check("basic_nwords", seen.size(), 8);
    if (seen.size() == 8) begin
      for (int i = 0; i < PKT_WORDS; i++) check($sformatf("basic_word%0d", i), seen[i], basic[i]);
    end
    check("basic_done_pulses", n_done, 1);

    // Busy channel: backoff length from the LFSR, frozen while busy
    seeds = '{16'h1D2F, 16'h0000};
    for (int s = 0; s < 2; s++) begin
      my_node_id = seeds[s];
      do_reset();
      rand_fields();
      ch_busy = 1'b1;
      reward_done = 16'h0001;
      tick();
      reward_done = '0;
      tick();
      bo_exp = int'(m_lfsr[4:0]) + 1;
      if (seeds[s] == 16'h0000) check("backoff_seed0_value", bo_exp, 8);
      for (int i = 0; i < 18; i++) begin
        tick();
        check("busy_no_valid", txb.tx_valid, 0);
      end
      ch_busy = 1'b0;
      wait_valid(100, n);
      check($sformatf("backoff_wait_seed%0d", s), n, bo_exp + 8);
      if (seeds[s] == 16'h0000) check("backoff_wait_seed0_literal", n, 16);
      drain();
    end
    my_node_id = 16'h1D2F;

    // Backpressure on words 3 and 4
    do_reset();
    rand_fields();
    seen.delete();
    n_done = 0;
    reward_done = 16'h0001;
    tick();
    reward_done = '0;
    st3 = 0;
    st4 = 0;
    n = 0;
    while (m_q.size() != 0 && n < 300) begin
      if (txb.tx_valid && m_widx == 3 && st3 < 3) begin
        txb.tx_ready = 1'b0;
        st3++;
      end else if (txb.tx_valid && m_widx == 4 && st4 < 3) begin
        txb.tx_ready = 1'b0;
        st4++;
      end else begin
        txb.tx_ready = 1'b1;
      end
      tick();
      n++;
    end
    txb.tx_ready = 1'b1;
    tick();
    check("bp_words", seen.size(), 8);
    check("bp_stalls", st3 + st4, 6);
    check("bp_done_pulses", n_done, 1);

    // Overflow: five captures into a four-deep queue while busy
    do_reset();
    seen.delete();
    n_drops = 0;
    ch_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_fields();
      reward_done = 16'h0001;
      tick();
    end
    reward_done = '0;
    tick();
    check("ovf_count", pkt_count, 4);
    check("ovf_drop_pulses", n_drops, 1);
    drain();
    check("ovf_words_sent", seen.size(), 32);

    // Capture coincident with the final-word handshake
    do_reset();
    seen.delete();
    ch_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_fields();
      reward_done = 16'h0001;
      tick();
    end
    reward_done = '0;
    ch_busy = 1'b0;
    n = 0;
    while (!(txb.tx_valid && txb.tx_eop) && n < 200) begin
      tick();
      n++;
    end
    check("simul_reached_eop", txb.tx_eop, 1);
    check("simul_count_before", pkt_count, 2);
    rand_fields();
    fld[0] = 16'hA5A5;
    new0 = fld[0];
    reward_done = 16'h0001;
    tick();
    reward_done = '0;
    check("simul_count_after", pkt_count, 2);
    drain();
    check("simul_words_sent", seen.size(), 24);
    if (seen.size() == 24) check("simul_new_pkt_last", seen[16], new0);

    // Reset in the middle of a packet
    do_reset();
    rand_fields();
    reward_done = 16'h0001;
    tick();
    reward_done = '0;
    n = 0;
    while (!(txb.tx_valid && m_widx == 5) && n < 100) begin
      tick();
      n++;
    end
    check("rst_mid_reached_word5", m_widx, 5);
    n_done = 0;
    nrst = 1'b1;
    tick();
    check("rst_mid_valid", txb.tx_valid, 0);
    check("rst_mid_count", pkt_count, 0);
    nrst = 1'b0;
    tick();
    tick();
    check("rst_mid_no_done", n_done, 0);
    rand_fields();
    seen.delete();
    reward_done = 16'h0001;
    tick();
    reward_done = '0;
    drain();
    check("rst_mid_fresh_words", seen.size(), 8);
    check("rst_mid_fresh_done", n_done, 1);

    // Randomized traffic, carrier bursts and backpressure
    my_node_id = word_t'($urandom);
    do_reset();
    n_done = 0;
    m_pops = 0;
    for (int c = 0; c < 1500; c++) begin
      rand_fields();
      reward_done = word_t'($urandom);
      reward_done[0] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 9) == 0) ch_busy = ~ch_busy;
      txb.tx_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    check("rand_done_vs_pops", n_done, m_pops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
